// File: rtl/inst_sram_resp_pkg.sv
// Shared constants and FSM encoding for the instruction-SRAM fetch responder.
package inst_sram_resp_pkg;

  localparam logic [31:0] INST_RESET_ADDR = 32'hbfc00000;
  localparam int unsigned LINE_WORDS_DEF  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2,
    StResp = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_sram_resp_if.sv
// Fetch-side and refill-side signals of the instruction-SRAM responder.
interface inst_sram_resp_if;

  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        inst_rvalid;
  logic        inst_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;

  modport slave (
    input  inst_sram_en, inst_sram_addr, flush, mem_ack, mem_rvalid, mem_rdata, mem_rlast,
    output inst_sram_rdata, inst_rvalid, inst_stall, mem_req, mem_addr
  );

  modport master (
    output inst_sram_en, inst_sram_addr, flush, mem_ack, mem_rvalid, mem_rdata, mem_rlast,
    input  inst_sram_rdata, inst_rvalid, inst_stall, mem_req, mem_addr
  );

endinterface

// File: rtl/inst_line_buf.sv
// Single line buffer: LINE_WORDS x 32 data, one tag, one valid bit and a hit comparator.
module inst_line_buf #(
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned IdxW = $clog2(LINE_WORDS),
  localparam int unsigned TagW = 30 - IdxW
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_wr_en,
  input  logic [IdxW-1:0] i_wr_idx,
  input  logic [31:0]     i_wr_data,
  input  logic            i_tag_ld,
  input  logic [TagW-1:0] i_tag,
  input  logic            i_set_valid,
  input  logic            i_clr_valid,
  input  logic [TagW-1:0] i_lk_tag,
  input  logic [IdxW-1:0] i_rd_idx,
  output logic [31:0]     o_rd_data,
  output logic            o_hit,
  output logic [TagW-1:0] o_tag
);

  logic [31:0]     r_line [LINE_WORDS];
  logic [TagW-1:0] r_tag;
  logic            r_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(LINE_WORDS); i++) r_line[i] <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_wr_en) r_line[i_wr_idx] <= i_wr_data;
      if (i_tag_ld) r_tag <= i_tag;
      if (i_set_valid) r_valid <= 1'b1;
      else if (i_clr_valid) r_valid <= 1'b0;
    end
  end

  assign o_rd_data = r_line[i_rd_idx];
  assign o_hit     = r_valid && (r_tag == i_lk_tag);
  assign o_tag     = r_tag;

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction-SRAM responder: serves hits from one line buffer, refills the line on a miss.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter logic [31:0] RESET_ADDR = INST_RESET_ADDR
) (
  input logic              clk,
  input logic              resetn,
  inst_sram_resp_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(LINE_WORDS);
  localparam int unsigned TagW = 30 - IdxW;

  if (RESET_ADDR[1:0] != 2'b00 || LINE_WORDS < 2 || LINE_WORDS > 16 ||
      (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_param_err
    $error("inst_sram_resp: bad LINE_WORDS or misaligned RESET_ADDR");
  end

  fetch_state_e    r_state, w_state_d;
  logic [IdxW-1:0] r_cnt, w_cnt_d, r_idx, w_idx_d;
  logic            r_flushed, w_flushed_d, r_rvalid, w_rvalid_d;
  logic [31:0]     r_rdata, w_rdata_d;

  logic [TagW-1:0] w_lk_tag, w_tag;
  logic [IdxW-1:0] w_lk_idx, w_rd_idx;
  logic [31:0]     w_rd_data;
  logic            w_tag_hit, w_hit, w_beat, w_last, w_stall;
  logic            w_wr_en, w_tag_ld, w_set_valid, w_clr_valid;

  assign w_lk_tag = bus.inst_sram_addr[31:IdxW+2];
  assign w_lk_idx = bus.inst_sram_addr[IdxW+1:2];
  assign w_rd_idx = (r_state == StIdle) ? w_lk_idx : r_idx;
  assign w_hit    = w_tag_hit && !bus.flush;
  // The first beat may arrive together with the ack.
  assign w_beat   = bus.mem_rvalid &&
                    (r_state == StFill || (r_state == StReq && bus.mem_ack));
  assign w_last   = bus.mem_rlast || (r_cnt == IdxW'(LINE_WORDS - 1));

  inst_line_buf #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk         (clk),
    .resetn      (resetn),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (r_cnt),
    .i_wr_data   (bus.mem_rdata),
    .i_tag_ld    (w_tag_ld),
    .i_tag       (w_lk_tag),
    .i_set_valid (w_set_valid),
    .i_clr_valid (w_clr_valid),
    .i_lk_tag    (w_lk_tag),
    .i_rd_idx    (w_rd_idx),
    .o_rd_data   (w_rd_data),
    .o_hit       (w_tag_hit),
    .o_tag       (w_tag)
  );

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_idx_d     = r_idx;
    w_flushed_d = r_flushed | bus.flush;
    w_rvalid_d  = 1'b0;
    w_rdata_d   = r_rdata;
    w_stall     = 1'b0;
    w_wr_en     = 1'b0;
    w_tag_ld    = 1'b0;
    w_set_valid = 1'b0;
    w_clr_valid = bus.flush;
    unique case (r_state)
      StIdle: begin
        if (bus.inst_sram_en) begin
          if (w_hit) begin
            w_rvalid_d = 1'b1;
            w_rdata_d  = w_rd_data;
          end else begin
            w_stall     = 1'b1;
            w_tag_ld    = 1'b1;
            w_idx_d     = w_lk_idx;
            w_clr_valid = 1'b1;
            w_flushed_d = 1'b0;
            w_cnt_d     = '0;
            w_state_d   = StReq;
          end
        end
      end
      StReq: begin
        w_stall = 1'b1;
        if (bus.mem_ack) w_state_d = StFill;
      end
      StFill: w_stall = 1'b1;
      StResp: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_beat) begin
      w_wr_en = 1'b1;
      w_cnt_d = r_cnt + 1'b1;
      if (w_last) begin
        w_cnt_d     = '0;
        w_state_d   = StResp;
        // A flush during refill still answers the stalled request but leaves the line invalid.
        w_set_valid = !(r_flushed || bus.flush);
        w_rvalid_d  = 1'b1;
        w_rdata_d   = (r_idx == r_cnt) ? bus.mem_rdata : w_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_flushed <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_idx     <= w_idx_d;
      r_flushed <= w_flushed_d;
      r_rvalid  <= w_rvalid_d;
      r_rdata   <= w_rdata_d;
    end
  end

  assign bus.inst_stall      = w_stall;
  assign bus.inst_rvalid     = r_rvalid;
  assign bus.inst_sram_rdata = r_rdata;
  assign bus.mem_req         = (r_state == StReq);
  assign bus.mem_addr        = (r_state == StReq) ? {w_tag, {(IdxW + 2){1'b0}}} : 32'h0;

endmodule
